pr_loopback_tester: RTL

//   Static-side initiator for one pr_loopback reconfigurable partition. Drives a
//   32-bit LFSR pattern into the partition's `in`, then checks the partition's
//   `out` against the expected value delayed by LB_LATENCY.

---
 rtl/pr_loopback_tester_if.sv | 14 +
 rtl/pr_loopback_tester.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pr_loopback_tester_if.sv
// Bus between the static-side tester and one pr_loopback reconfigurable partition.
//   rp_in    : pattern word driven into the partition (tester -> RP)
//   rp_out   : partition output word (RP -> tester)
//   decouple : high while the partition is being reprogrammed (static side -> both)
interface pr_loopback_tester_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] rp_in;
  logic [DATA_W-1:0] rp_out;
  logic              decouple;

  modport master (output rp_in, input rp_out, input decouple);
  modport slave  (input rp_in, output rp_out, input decouple);
endinterface

// File: rtl/pr_loopback_tester.sv
// Static-side initiator for one pr_loopback reconfigurable partition.
// Drives a 32-bit Galois LFSR pattern into the RP and checks the RP output
// against the same word delayed by LB_LATENCY, counting passes and errors.
// Ports:
//   clock, reset_n : sys_clk and synchronous active-low reset
//   start, stop    : control pulses (stop wins when both are high)
//   rp             : RP bus (rp_in registered out, rp_out and decouple in)
//   busy, fail     : state != IDLE; sticky mismatch flag
//   pass_cnt       : matched words, saturating
//   err_cnt        : mismatched words, saturating
//   state          : 0 IDLE, 1 RUN, 2 HOLD, 3 FAIL
//   err_exp/err_act: first-mismatch capture, only when PR_LB_ERR_CAPTURE_EN is defined
module pr_loopback_tester #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          LB_LATENCY = 1,
  parameter logic [31:0]          LFSR_SEED  = 32'h0000_0001,
  parameter int unsigned          ERR_CNT_W  = 16,
  parameter logic [ERR_CNT_W-1:0] ERR_LIMIT  = 16'd16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  pr_loopback_tester_if.master rp,
  output logic                 busy,
  output logic                 fail,
  output logic [31:0]          pass_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           state
`ifdef PR_LB_ERR_CAPTURE_EN
  ,
  output logic [DATA_W-1:0]    err_exp,
  output logic [DATA_W-1:0]    err_act
`endif
);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t                           st_q;
  logic [31:0]                      lfsr_q;
  logic [31:0]                      lfsr_nxt;
  // Stage 0 mirrors the word currently on rp_in; stage LB_LATENCY is due for compare.
  logic [LB_LATENCY:0][DATA_W-1:0]  exp_q;
  logic [LB_LATENCY:0]              vld_q;
  logic                             cmp_match;
  logic                             err_sat;
  logic                             lim_hit;

  assign lfsr_nxt  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  assign cmp_match = (exp_q[LB_LATENCY] == rp.rp_out);
  assign err_sat   = (err_cnt == {ERR_CNT_W{1'b1}});
  assign lim_hit   = (ERR_LIMIT != '0) && (ERR_CNT_W'(err_cnt + ERR_CNT_W'(1)) == ERR_LIMIT);
  assign state     = st_q;

  // State, pattern generation, compare pipeline and counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st_q     <= ST_IDLE;
      busy     <= 1'b0;
      fail     <= 1'b0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      rp.rp_in <= '0;
      lfsr_q   <= LFSR_SEED;
      exp_q    <= '0;
      vld_q    <= '0;
`ifdef PR_LB_ERR_CAPTURE_EN
      err_exp  <= '0;
      err_act  <= '0;
`endif
    end else begin
      case (st_q)
        ST_IDLE: begin
          rp.rp_in <= '0;
          vld_q    <= '0;
          if (start && !stop) begin
            st_q     <= ST_RUN;
            busy     <= 1'b1;
            lfsr_q   <= LFSR_SEED;
            fail     <= 1'b0;
            pass_cnt <= '0;
            err_cnt  <= '0;
`ifdef PR_LB_ERR_CAPTURE_EN
            err_exp  <= '0;
            err_act  <= '0;
`endif
          end
        end

        ST_RUN, ST_HOLD: begin
          if (stop) begin
            st_q     <= ST_IDLE;
            busy     <= 1'b0;
            rp.rp_in <= '0;
            vld_q    <= '0;
          end else if (start) begin
            st_q     <= ST_RUN;
            busy     <= 1'b1;
            rp.rp_in <= '0;
            vld_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            fail     <= 1'b0;
            pass_cnt <= '0;
            err_cnt  <= '0;
`ifdef PR_LB_ERR_CAPTURE_EN
            err_exp  <= '0;
            err_act  <= '0;
`endif
          end else if (rp.decouple) begin
            // Anything in flight is lost; warm-up restarts after release.
            st_q     <= ST_HOLD;
            rp.rp_in <= '0;
            vld_q    <= '0;
          end else if (st_q == ST_HOLD) begin
            // Released: rp_in stays 0 this cycle, pattern resumes next cycle.
            st_q     <= ST_RUN;
            rp.rp_in <= '0;
            vld_q    <= '0;
          end else begin
            rp.rp_in <= DATA_W'(lfsr_q);
            lfsr_q   <= lfsr_nxt;
            exp_q    <= {exp_q[LB_LATENCY-1:0], DATA_W'(lfsr_q)};
            vld_q    <= {vld_q[LB_LATENCY-1:0], 1'b1};
            if (vld_q[LB_LATENCY]) begin
              if (cmp_match) begin
                if (pass_cnt != 32'hFFFF_FFFF) pass_cnt <= pass_cnt + 32'd1;
              end else begin
                fail <= 1'b1;
                if (!err_sat) err_cnt <= err_cnt + ERR_CNT_W'(1);
`ifdef PR_LB_ERR_CAPTURE_EN
                if (!fail) begin
                  err_exp <= exp_q[LB_LATENCY];
                  err_act <= rp.rp_out;
                end
`endif
                if (lim_hit) begin
                  st_q     <= ST_FAIL;
                  rp.rp_in <= '0;
                  vld_q    <= '0;
                end
              end
            end
          end
        end

        ST_FAIL: begin
          rp.rp_in <= '0;
          vld_q    <= '0;
          if (start && !stop) begin
            st_q     <= ST_RUN;
            busy     <= 1'b1;
            lfsr_q   <= LFSR_SEED;
            fail     <= 1'b0;
            pass_cnt <= '0;
            err_cnt  <= '0;
`ifdef PR_LB_ERR_CAPTURE_EN
            err_exp  <= '0;
            err_act  <= '0;
`endif
          end
        end

        default: begin
          st_q <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
